data_ram_ctrl: RTL

Data-memory responder at the far end of the cache's RAM port. It accepts one word-wide read or write request at a time from the cache miss/write-through path, and performs byte-masked writes into an internal word array. After a fixed, parameterised access latency it returns one `ram_data_ready` pulse with read data. It replaces the ideal single-cycle data RAM in the SoC top, so cache stall behaviour can be exercised against realistic memory timing.

---
 rtl/data_ram_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/data_ram_ctrl.sv
// Latency-modelling data RAM responder for the cache RAM port.
// Serialises one byte-masked word access at a time and pulses ready once per request.
module data_ram_ctrl #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ce_i,
   input  logic        ram_we_i,
   input  logic [31:0] ram_addr_i,
   input  logic [3:0]  ram_sel_i,
   input  logic [31:0] ram_data_i,
   output logic [31:0] ram_data_o,
   output logic        ram_data_ready_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp, StWaitLow} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   accept, access;

   logic                   we_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [3:0]             sel_q;
   logic [31:0]            data_q;
   logic [31:0]            rdata_q;

   logic [31:0]            mem [2**ADDR_BITS];

   // Byte offset and bits above the array size alias away.
   logic                   unused_addr;
   assign unused_addr = ^{ram_addr_i[31:ADDR_BITS+2], ram_addr_i[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ram_ce_i) begin
               accept  = 1'b1;
               cnt_d   = 4'(LATENCY - 1);
               state_d = StBusy;
            end
         end
         StBusy: begin
            // Counter expiry lands the access exactly LATENCY edges after acceptance.
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = ram_ce_i ? StWaitLow : StIdle;
         end
         StWaitLow: begin
            if (!ram_ce_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= 4'd0;
         data_q  <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q   <= ram_we_i;
            addr_q <= ram_addr_i[ADDR_BITS+1:2];
            sel_q  <= ram_sel_i;
            data_q <= ram_data_i;
         end
         if (access && !we_q) rdata_q <= mem[addr_q];
      end
   end

   // Array contents are deliberately not reset; reset only suppresses a pending write.
   always_ff @(posedge clk) begin
      if (!rst && access && we_q) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) mem[addr_q][8*i +: 8] <= data_q[8*i +: 8];
         end
      end
   end

   assign ram_data_o       = rdata_q;
   assign ram_data_ready_o = (state_q == StResp);
   assign busy_o           = (state_q != StIdle);

endmodule
